// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out transmit scheduler.
package piso_pkg;

  typedef logic [1:0] piso_state_t;

  localparam piso_state_t StIdle  = 2'd0;
  localparam piso_state_t StShift = 2'd1;
  localparam piso_state_t StGap   = 2'd2;

  // Arbiter helper is sized for the largest supported requester count.
  localparam int unsigned RrMaxReq = 32;

  // First valid index at or after ptr, wrapping modulo nreq. Returns ptr when nothing is valid.
  function automatic logic [4:0] rr_pick(input logic [RrMaxReq-1:0] valid,
                                         input logic [4:0]          ptr,
                                         input logic [5:0]          nreq);
    logic [5:0] idx;
    logic       found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 0; i < RrMaxReq; i++) begin
      idx = {1'b0, ptr} + 6'(i);
      if (idx >= nreq) begin
        idx = idx - nreq;
      end
      if (!found && (6'(i) < nreq) && valid[idx[4:0]]) begin
        rr_pick = idx[4:0];
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/piso_shift_core.sv
// Left-shifting register with zero fill; a synchronous load takes priority over a shift.
module piso_shift_core #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] shreg_q, shreg_d;

  always_comb begin
    shreg_d = shreg_q;
    if (load) begin
      shreg_d = din;
    end else if (shift) begin
      shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign msb = shreg_q[WIDTH-1];

endmodule

// File: rtl/piso_tx_sched.sv
// Round-robin scheduler sharing one serial lane between NREQ word producers.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_tx_sched
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NREQ  = 2,
  parameter int unsigned GAP   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    ser_out,
  output logic                    frame,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    done
);

  localparam int unsigned IdW   = $clog2(NREQ);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
`ifdef PISO_PARITY_EN
  localparam int unsigned FrameLen = WIDTH + 1;
`else
  localparam int unsigned FrameLen = WIDTH;
`endif
  localparam logic [CNT_W-1:0] CntInit = CNT_W'(FrameLen - 1);
  localparam int unsigned      GapW    = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GapW-1:0]  GapInit = GapW'((GAP > 0) ? GAP - 1 : 0);

  piso_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GapW-1:0]  gap_q, gap_d;
  logic [IdW-1:0]   ptr_q, ptr_d;
  logic [IdW-1:0]   gid_q, gid_d;
  logic             ser_q, ser_d;
  logic             frame_q, frame_d;

  logic [IdW-1:0]   winner;
  logic [WIDTH-1:0] word_sel;
  logic [WIDTH-1:0] load_word;
  logic             any_valid;
  logic             load_en;
  logic             shift_en;
  logic             core_msb;

  assign any_valid = |req_valid;
  assign winner    = IdW'(rr_pick(32'(req_valid), 5'(ptr_q), 6'(NREQ)));
  assign word_sel  = req_data[winner*WIDTH +: WIDTH];

  // The MSB goes straight to the output flop at acceptance, so the core holds the word
  // pre-shifted by one; the vacated LSB carries the parity bit when it is enabled.
`ifdef PISO_PARITY_EN
  assign load_word = {word_sel[WIDTH-2:0], ^word_sel};
`else
  assign load_word = {word_sel[WIDTH-2:0], 1'b0};
`endif

  piso_shift_core #(
    .WIDTH(WIDTH)
  ) u_shift_core (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load_en),
    .shift(shift_en),
    .din  (load_word),
    .msb  (core_msb)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    ptr_d    = ptr_q;
    gid_d    = gid_q;
    ser_d    = 1'b0;
    frame_d  = 1'b0;
    load_en  = 1'b0;
    shift_en = 1'b0;
    case (state_q)
      StIdle: begin
        if (any_valid) begin
          load_en = 1'b1;
          gid_d   = winner;
          ptr_d   = (winner == IdW'(NREQ - 1)) ? '0 : winner + 1'b1;
          cnt_d   = CntInit;
          ser_d   = word_sel[WIDTH-1];
          frame_d = 1'b1;
          state_d = StShift;
        end
      end
      StShift: begin
        shift_en = 1'b1;
        if (cnt_q == '0) begin
          if (GAP > 0) begin
            gap_d   = GapInit;
            state_d = StGap;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d   = cnt_q - 1'b1;
          ser_d   = core_msb;
          frame_d = 1'b1;
        end
      end
      StGap: begin
        if (gap_q == '0) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      gap_q   <= '0;
      ptr_q   <= '0;
      gid_q   <= '0;
      ser_q   <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      ser_q   <= ser_d;
      frame_q <= frame_d;
    end
  end

  // No handshake may complete while the flops are held in reset.
  always_comb begin
    req_ready = '0;
    if ((state_q == StIdle) && any_valid && rst_n) begin
      req_ready[winner] = 1'b1;
    end
  end

  assign ser_out  = ser_q;
  assign frame    = frame_q;
  assign grant_id = gid_q;
  assign done     = (state_q == StShift) && (cnt_q == '0);

endmodule

// File: tb/tb_piso_tx_sched.sv
// Directed bench for piso_tx_sched: three instances (GAP=1, GAP=0, NREQ=3) sharing one clock.
module tb_piso_tx_sched;

  localparam int W = 4;
`ifdef PISO_PARITY_EN
  localparam int FLen = W + 1;
`else
  localparam int FLen = W;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  vld [3];
  logic [11:0] dat [3];

  logic [1:0] rdy_a, rdy_b;
  logic [2:0] rdy_c;
  logic       ser_a, ser_b, ser_c, frm_a, frm_b, frm_c, done_a, done_b, done_c;
  logic       gid_a, gid_b;
  logic [1:0] gid_c;

  piso_tx_sched #(.WIDTH(4), .NREQ(2), .GAP(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(vld[0][1:0]), .req_data(dat[0][7:0]),
    .req_ready(rdy_a), .ser_out(ser_a), .frame(frm_a), .grant_id(gid_a), .done(done_a)
  );
  piso_tx_sched #(.WIDTH(4), .NREQ(2), .GAP(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(vld[1][1:0]), .req_data(dat[1][7:0]),
    .req_ready(rdy_b), .ser_out(ser_b), .frame(frm_b), .grant_id(gid_b), .done(done_b)
  );
  piso_tx_sched #(.WIDTH(4), .NREQ(3), .GAP(1)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .req_valid(vld[2]), .req_data(dat[2]),
    .req_ready(rdy_c), .ser_out(ser_c), .frame(frm_c), .grant_id(gid_c), .done(done_c)
  );

  logic [2:0] o_rdy [3];
  logic [1:0] o_gid [3];
  logic       o_ser [3];
  logic       o_frm [3];
  logic       o_done [3];

  assign o_rdy[0] = {1'b0, rdy_a};
  assign o_rdy[1] = {1'b0, rdy_b};
  assign o_rdy[2] = rdy_c;
  assign o_gid[0] = {1'b0, gid_a};
  assign o_gid[1] = {1'b0, gid_b};
  assign o_gid[2] = gid_c;
  assign o_ser[0] = ser_a;
  assign o_ser[1] = ser_b;
  assign o_ser[2] = ser_c;
  assign o_frm[0] = frm_a;
  assign o_frm[1] = frm_b;
  assign o_frm[2] = frm_c;
  assign o_done[0] = done_a;
  assign o_done[1] = done_b;
  assign o_done[2] = done_c;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input int u, input logic ser, input logic frm,
                         input logic dn, input logic [2:0] rdy);
    check_eq({tag, ".ser"}, 32'(o_ser[u]), 32'(ser));
    check_eq({tag, ".frame"}, 32'(o_frm[u]), 32'(frm));
    check_eq({tag, ".done"}, 32'(o_done[u]), 32'(dn));
    check_eq({tag, ".rdy"}, 32'(o_rdy[u]), 32'(rdy));
  endtask

  // Caller has already advanced to the first frame cycle and settled its inputs.
  task automatic expect_frame(input string tag, input int u, input logic [3:0] word,
                              input logic [1:0] gid, input int raise_at,
                              input logic [2:0] raise_mask);
    logic b;
    for (int k = 0; k < FLen; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
        if (k == raise_at) vld[u] = vld[u] | raise_mask;
        #1;
      end
      b = (k < W) ? word[W-1-k] : ^word;
      chk_out($sformatf("%s.b%0d", tag, k), u, b, 1'b1, (k == FLen - 1), 3'b000);
      check_eq($sformatf("%s.b%0d.gid", tag, k), 32'(o_gid[u]), 32'(gid));
    end
  endtask

  // Entered at the start of an IDLE cycle with valid already driven; gseq packs 2-bit grants.
  task automatic run_grants(input string tag, input int u, input int gap, input int n,
                            input logic [7:0] gseq);
    logic [1:0] g;
    logic [3:0] w;
    for (int f = 0; f < n; f++) begin
      g = gseq[2*f +: 2];
      w = dat[u][4*g +: 4];
      #1;
      check_eq($sformatf("%s.f%0d.rdy", tag, f), 32'(o_rdy[u]), 32'(3'b001 << g));
      check_eq($sformatf("%s.f%0d.idle_frame", tag, f), 32'(o_frm[u]), 32'(0));
      step();
      #1;
      expect_frame($sformatf("%s.f%0d", tag, f), u, w, g, -1, 3'b000);
      for (int k = 0; k < gap; k++) begin
        step();
        #1;
        chk_out($sformatf("%s.f%0d.gap%0d", tag, f, k), u, 1'b0, 1'b0, 1'b0, 3'b000);
      end
      step();
    end
  endtask

  task automatic do_reset();
    for (int u = 0; u < 3; u++) begin
      vld[u] = '0;
      dat[u] = '0;
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int u = 0; u < 3; u++) begin
      vld[u] = '0;
      dat[u] = '0;
    end
    // Reset values, including a valid request that must not be acknowledged during reset.
    #12;
    chk_out("reset", 0, 1'b0, 1'b0, 1'b0, 3'b000);
    check_eq("reset.gid", 32'(o_gid[0]), 32'(0));
    vld[0] = 3'b011;
    #1;
    check_eq("reset.rdy_gated", 32'(o_rdy[0]), 32'(0));
    vld[0] = '0;
    step();
    rst_n = 1'b1;

    // Single request: 1011 shifted MSB first, done on the last frame cycle.
    dat[0] = 12'h00B;
    vld[0] = 3'b001;
    run_grants("single", 0, 1, 1, 8'h00);
    vld[0] = '0;
    #1;
    chk_out("single.idle", 0, 1'b0, 1'b0, 1'b0, 3'b000);

    // Contention with GAP=1 then GAP=0: grants 0,1,0,1 carrying A,5,A,5.
    do_reset();
    dat[0] = 12'h05A;
    vld[0] = 3'b011;
    run_grants("cont_g1", 0, 1, 4, 8'h44);
    vld[0] = '0;
    do_reset();
    dat[1] = 12'h05A;
    vld[1] = 3'b011;
    run_grants("cont_g0", 1, 0, 4, 8'h44);
    vld[1] = '0;

    // Late request: req1 rises mid-frame and waits for the next IDLE.
    do_reset();
    dat[0] = 12'h03C;
    vld[0] = 3'b001;
    #1;
    check_eq("late.rdy0", 32'(o_rdy[0]), 32'(3'b001));
    step();
    vld[0] = '0;
    #1;
    expect_frame("late0", 0, 4'hC, 2'd0, 2, 3'b010);
    step();
    #1;
    chk_out("late.gap", 0, 1'b0, 1'b0, 1'b0, 3'b000);
    step();
    run_grants("late1", 0, 1, 1, 8'h01);
    vld[0] = '0;

    // Reset after two bits aborts the frame; the pending req1 is granted afterwards.
    do_reset();
    dat[0] = 12'h02B;
    vld[0] = 3'b001;
    #1;
    check_eq("abort.rdy0", 32'(o_rdy[0]), 32'(3'b001));
    step();
    vld[0] = 3'b010;
    #1;
    chk_out("abort.b0", 0, 1'b1, 1'b1, 1'b0, 3'b000);
    step();
    #1;
    chk_out("abort.b1", 0, 1'b0, 1'b1, 1'b0, 3'b000);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("abort.in_reset", 0, 1'b0, 1'b0, 1'b0, 3'b000);
    check_eq("abort.gid", 32'(o_gid[0]), 32'(0));
    step();
    rst_n = 1'b1;
    run_grants("abort.req1", 0, 1, 1, 8'h01);
    vld[0] = '0;

    // Pointer wrap with NREQ=3: grant req1 to park the pointer at 2, then 101 gives 2,0,2.
    do_reset();
    dat[2] = 12'h963;
    vld[2] = 3'b010;
    run_grants("wrap_pre", 2, 1, 1, 8'h01);
    vld[2] = 3'b101;
    run_grants("wrap", 2, 1, 3, 8'h22);
    vld[2] = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
